circular_pointer_mc_fifo: RTL and testbench
===========================================

Name: circular_pointer_mc_fifo

Overview:
- Multi-channel successor to the single-queue circular-pointer FIFO: NCH independent circular queues, each DEPTH entries of WIDTH bits, sharing one push port and one pop port, each port steered by a channel select.
- Adds a selectable output mode (fall-through or registered), non-power-of-2 depth, per-channel occupancy counts, and sticky overflow/underflow error flags.
- Drops into the existing scoreboard-based formal top in place of the single FIFO. The top instantiates one scoreboard per channel or checks a chosen channel.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 5, entries per channel; any value >= 2, power of 2 not required.
- NCH, 2, number of channels; >= 1.
- REG_OUT, 0, output mode: 0 = fall-through head of pop_ch; 1 = registered popped word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write request.
- push_ch  input  CHW  target channel for push; CHW = max(1,$clog2(NCH)).
- data_in  input  WIDTH  write data.
- pop  input  1  read request.
- pop_ch  input  CHW  source channel for pop; also selects data_out in REG_OUT=0.
- clr_err  input  1  synchronous clear of ovf_err and udf_err.
- data_out  output  WIDTH  read data.
- data_out_vld  output  1  data_out valid.
- empty  output  NCH  per-channel empty.
- full  output  NCH  per-channel full.
- count  output  NCH*CNTW  per-channel occupancy, flattened, channel 0 in the LSBs; CNTW = $clog2(DEPTH+1).
- ovf_err  output  1  sticky: push to a full channel was dropped.
- udf_err  output  1  sticky: pop from an empty channel was ignored.

Behaviour:
- Reset (rst low, asynchronous):
  - all read and write pointers and counts go to 0.
  - empty = all ones; full = 0; ovf_err = udf_err = 0.
  - data_out_vld = 0.
  - data_out register = 0 in REG_OUT=1. Storage is not reset.
- Reset mid-operation discards all contents immediately. The first post-reset push is accepted on the first clk edge with rst high.
- Per channel c:
  - wr_ptr and rd_ptr each range 0..DEPTH-1 and wrap from DEPTH-1 to 0.
  - count is 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
  - Flags are derived combinationally from registered count.
- Push accept: push && (!full[push_ch] || pop accepted on the same channel this cycle).
  - On accept: mem[c][wr_ptr] <= data_in; wr_ptr advances.
- Pop accept: pop && !empty[pop_ch]. No empty bypass: a pop with a same-cycle push to an empty channel is rejected.
  - On accept: rd_ptr advances.
- count update:
  - +1 on push-only accept.
  - -1 on pop-only accept.
  - unchanged when both are accepted on the same channel.
  - push and pop to different channels update each channel independently.
- Full channel, push and pop both targeting it: both accepted, count stays DEPTH, no ovf_err.
- Rejected push: ovf_err <= 1. Rejected pop: udf_err <= 1. Pushes or pops with the request low never flag.
- clr_err clears both flags. A same-cycle new error wins, so the flag stays 1.
- REG_OUT=0:
  - data_out = mem[pop_ch][rd_ptr[pop_ch]], combinational, zero latency.
  - data_out_vld = !empty[pop_ch].
- REG_OUT=1:
  - on an accepted pop, data_out <= head word and data_out_vld <= 1 on the next edge.
  - otherwise data_out_vld <= 0 and data_out holds its value.
  - Latency: 1 cycle.
- pop_ch or push_ch >= NCH (non-power-of-2 NCH): treated as a rejected request and flags the matching error.
- No internal assumptions on environment; protocol constraints (no push when full, no pop when empty) are the formal top's job.

Decomposition:
- Shared package circular_pointer_pkg:
  - CHW and CNTW width functions.
  - a ptr_wrap(ptr, DEPTH) increment-with-wrap function.
  - REG_OUT mode constants.
- One sub-module, circular_pointer_chan:
  - per-channel pointers, count, storage, flags.
  - inputs are already-decoded push_en/pop_en.
- The top handles:
  - decoding and acceptance.
  - the error flags.
  - the output mux/register.

Test Plan:
- Reset, then 5 pushes to ch0 (0x11..0x15) -> full=2'b01, count ch0=5, empty=2'b10. A 6th push of 0x16 -> dropped, ovf_err=1, count stays 5.
- Continuing from the previous scenario, pop ch0 five times, REG_OUT=0 -> data_out 0x11..0x15 in order, each valid the same cycle. Then empty[0]=1; a further pop -> udf_err=1.
- Wrap-around: push 3, pop 3, push 4 (0xA0..0xA3) on ch1 with DEPTH=5 -> wr_ptr wraps through 4->0; pops return 0xA0..0xA3 in order.
- Full ch0 plus simultaneous push 0x77 and pop on ch0 -> pops the head, accepts 0x77, count=5, no ovf_err. 0x77 emerges as the 5th subsequent pop.
- Cross-channel interleave: push ch0 0x01, push ch1 0x02, same cycle pop ch1 and push ch0 0x03 -> ch1 returns 0x02, ch0 count=2, ch1 empty. REG_OUT=1 variant: data_out=0x02 with data_out_vld=1 one cycle after the pop.
- Async reset asserted mid-stream with ch0 count=3 -> count, flags and vld clear immediately, without waiting for a clk edge. clr_err pulse with a concurrent bad pop -> udf_err stays 1.

Source files
------------

// File: rtl/circular_pointer_pkg.sv
// circular_pointer_pkg: shared widths, pointer wrap helper and output-mode constants
package circular_pointer_pkg;
    localparam int REG_OUT_FT  = 0;
    localparam int REG_OUT_REG = 1;

    function automatic int chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int cntw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_wrap(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/circular_pointer_chan.sv
// circular_pointer_chan: one circular queue with pointers, occupancy count and flags
module circular_pointer_chan
    import circular_pointer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    localparam int CNTW = cntw(DEPTH),
    localparam int PTRW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_en_i,
    input  logic             pop_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNTW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // next pointers wrap at DEPTH-1; count moves only on a one-sided access
    always_comb begin
        wr_ptr_d = push_en_i ? PTRW'(ptr_wrap(int'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = pop_en_i ? PTRW'(ptr_wrap(int'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        count_d  = (push_en_i && !pop_en_i) ? count_q + 1'b1 :
                   (pop_en_i && !push_en_i) ? count_q - 1'b1 : count_q;
    end

    // pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (push_en_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNTW'(DEPTH));
endmodule

// File: rtl/circular_pointer_mc_fifo.sv
// circular_pointer_mc_fifo: NCH circular queues behind shared push/pop ports with error flags
module circular_pointer_mc_fifo
    import circular_pointer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 5,
    parameter int NCH     = 2,
    parameter int REG_OUT = 0,
    localparam int CHW  = chw(NCH),
    localparam int CNTW = cntw(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [CHW-1:0]      push_ch_i,
    input  logic [WIDTH-1:0]    data_in_i,
    input  logic                pop_i,
    input  logic [CHW-1:0]      pop_ch_i,
    input  logic                clr_err_i,
    output logic [WIDTH-1:0]    data_out_o,
    output logic                data_out_vld_o,
    output logic [NCH-1:0]      empty_o,
    output logic [NCH-1:0]      full_o,
    output logic [NCH*CNTW-1:0] count_o,
    output logic                ovf_err_o,
    output logic                udf_err_o
);
    logic             push_chv, pop_chv, head_empty, pop_acc, push_acc;
    logic             ovf_q, ovf_d, udf_q, udf_d, vld_q, vld_d;
    logic [WIDTH-1:0] head [NCH];
    logic [WIDTH-1:0] head_sel, dout_q, dout_d;

    // channel decode, acceptance and next error/output state; out-of-range channels never accept
    always_comb begin
        push_chv   = int'(push_ch_i) < NCH;
        pop_chv    = int'(pop_ch_i) < NCH;
        head_empty = pop_chv ? empty_o[pop_ch_i] : 1'b1;
        head_sel   = pop_chv ? head[pop_ch_i] : '0;
        pop_acc    = pop_i && !head_empty;
        push_acc   = push_i && push_chv &&
                     (!full_o[push_ch_i] || (pop_acc && pop_ch_i == push_ch_i));
        ovf_d      = (ovf_q && !clr_err_i) || (push_i && !push_acc);
        udf_d      = (udf_q && !clr_err_i) || (pop_i && !pop_acc);
        dout_d     = pop_acc ? head_sel : dout_q;
        vld_d      = pop_acc;
    end

    // sticky errors and the registered output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            vld_q  <= vld_d;
            dout_q <= dout_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        circular_pointer_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .push_en_i (push_acc && push_ch_i == CHW'(c)),
            .pop_en_i  (pop_acc && pop_ch_i == CHW'(c)),
            .data_i    (data_in_i),
            .head_o    (head[c]),
            .count_o   (count_o[c*CNTW +: CNTW]),
            .empty_o   (empty_o[c]),
            .full_o    (full_o[c])
        );
    end

    assign data_out_o     = (REG_OUT == REG_OUT_REG) ? dout_q : head_sel;
    assign data_out_vld_o = (REG_OUT == REG_OUT_REG) ? vld_q : !head_empty;
    assign ovf_err_o      = ovf_q;
    assign udf_err_o      = udf_q;
endmodule

// File: tb/tb_circular_pointer_mc_fifo.sv
// tb_circular_pointer_mc_fifo: table vectors, corner sequences and random traffic vs a queue model
module tb_circular_pointer_mc_fifo;
    localparam int NCH = 2, DEPTH = 5, CNTW = 3;

    logic clk = 0, rst_n = 0;
    logic push = 0, push_ch = 0, pop = 0, pop_ch = 0, clr = 0;
    logic [7:0] din = 0;
    logic [7:0] dout0, dout1;
    logic vld0, vld1, ovf0, ovf1, udf0, udf1;
    logic [NCH-1:0] empty0, empty1, full0, full1;
    logic [NCH*CNTW-1:0] cnt0, cnt1;

    int checks = 0, passes = 0;
    logic [7:0] mq [NCH][$];
    bit m_ovf, m_udf, m_rvld;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    circular_pointer_mc_fifo #(.WIDTH(8), .DEPTH(DEPTH), .NCH(NCH), .REG_OUT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .push_ch_i(push_ch), .data_in_i(din),
        .pop_i(pop), .pop_ch_i(pop_ch), .clr_err_i(clr), .data_out_o(dout0),
        .data_out_vld_o(vld0), .empty_o(empty0), .full_o(full0), .count_o(cnt0),
        .ovf_err_o(ovf0), .udf_err_o(udf0));

    circular_pointer_mc_fifo #(.WIDTH(8), .DEPTH(DEPTH), .NCH(NCH), .REG_OUT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .push_ch_i(push_ch), .data_in_i(din),
        .pop_i(pop), .pop_ch_i(pop_ch), .clr_err_i(clr), .data_out_o(dout1),
        .data_out_vld_o(vld1), .empty_o(empty1), .full_o(full1), .count_o(cnt1),
        .ovf_err_o(ovf1), .udf_err_o(udf1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int cnt_of(input logic [NCH*CNTW-1:0] v, input int c);
        return int'(v[c*CNTW +: CNTW]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_ovf = 0; m_udf = 0; m_rvld = 0; m_rdata = 0;
    endtask

    task automatic check_state();
        logic [NCH-1:0] e_empty, e_full;
        for (int c = 0; c < NCH; c++) begin
            e_empty[c] = mq[c].size() == 0;
            e_full[c]  = mq[c].size() == DEPTH;
            chk($sformatf("count0_c%0d", c), cnt_of(cnt0, c), mq[c].size());
            chk($sformatf("count1_c%0d", c), cnt_of(cnt1, c), mq[c].size());
        end
        chk("empty0", empty0, e_empty);
        chk("empty1", empty1, e_empty);
        chk("full0", full0, e_full);
        chk("full1", full1, e_full);
        chk("ovf0", ovf0, m_ovf);
        chk("udf0", udf0, m_udf);
        chk("ovf1", ovf1, m_ovf);
        chk("udf1", udf1, m_udf);
        chk("reg_vld", vld1, m_rvld);
        chk("reg_data", dout1, m_rdata);
        chk("ft_vld_post", vld0, mq[pop_ch].size() != 0);
    endtask

    task automatic run(input bit pu, input int pch, input logic [7:0] d, input bit po,
                       input int poch, input bit cl, output logic [7:0] ft, output bit fv);
        bit pok, uok;
        @(negedge clk);
        push = pu; push_ch = pch[0]; din = d; pop = po; pop_ch = poch[0]; clr = cl;
        #1;
        fv = vld0; ft = dout0;
        chk("ft_vld", vld0, mq[poch].size() != 0);
        if (mq[poch].size() != 0) chk("ft_data", dout0, mq[poch][0]);
        @(posedge clk);
        pok = po && mq[poch].size() > 0;
        uok = pu && (mq[pch].size() < DEPTH || (pok && poch == pch));
        if (pok) m_rdata = mq[poch].pop_front();
        m_rvld = pok;
        if (uok) mq[pch].push_back(d);
        m_ovf = (m_ovf && !cl) || (pu && !uok);
        m_udf = (m_udf && !cl) || (po && !pok);
        #1;
        check_state();
    endtask

    typedef struct {
        bit pu; int pch; logic [7:0] d; bit po; int poch; bit cl;
        bit fv; logic [7:0] fd; int c0; int c1; bit ov; bit ud;
    } vec_t;

    function automatic vec_t v(bit pu, int pch, logic [7:0] d, bit po, int poch, bit cl,
                               bit fv, logic [7:0] fd, int c0, int c1, bit ov, bit ud);
        vec_t r;
        r.pu = pu; r.pch = pch; r.d = d; r.po = po; r.poch = poch; r.cl = cl;
        r.fv = fv; r.fd = fd; r.c0 = c0; r.c1 = c1; r.ov = ov; r.ud = ud;
        return r;
    endfunction

    initial begin
        vec_t tbl[27];
        logic [7:0] ft;
        bit fv;
        tbl[0]  = v(1,0,8'h11,0,0,0, 0,8'h00,1,0,0,0);
        tbl[1]  = v(1,0,8'h12,0,0,0, 1,8'h11,2,0,0,0);
        tbl[2]  = v(1,0,8'h13,0,0,0, 1,8'h11,3,0,0,0);
        tbl[3]  = v(1,0,8'h14,0,0,0, 1,8'h11,4,0,0,0);
        tbl[4]  = v(1,0,8'h15,0,0,0, 1,8'h11,5,0,0,0);
        tbl[5]  = v(1,0,8'h16,0,0,0, 1,8'h11,5,0,1,0);
        tbl[6]  = v(0,0,8'h00,1,0,0, 1,8'h11,4,0,1,0);
        tbl[7]  = v(0,0,8'h00,1,0,0, 1,8'h12,3,0,1,0);
        tbl[8]  = v(0,0,8'h00,1,0,0, 1,8'h13,2,0,1,0);
        tbl[9]  = v(0,0,8'h00,1,0,0, 1,8'h14,1,0,1,0);
        tbl[10] = v(0,0,8'h00,1,0,0, 1,8'h15,0,0,1,0);
        tbl[11] = v(0,0,8'h00,1,0,0, 0,8'h00,0,0,1,1);
        tbl[12] = v(0,0,8'h00,0,0,1, 0,8'h00,0,0,0,0);
        tbl[13] = v(1,1,8'hB0,0,1,0, 0,8'h00,0,1,0,0);
        tbl[14] = v(1,1,8'hB1,0,1,0, 1,8'hB0,0,2,0,0);
        tbl[15] = v(1,1,8'hB2,0,1,0, 1,8'hB0,0,3,0,0);
        tbl[16] = v(0,1,8'h00,1,1,0, 1,8'hB0,0,2,0,0);
        tbl[17] = v(0,1,8'h00,1,1,0, 1,8'hB1,0,1,0,0);
        tbl[18] = v(0,1,8'h00,1,1,0, 1,8'hB2,0,0,0,0);
        tbl[19] = v(1,1,8'hA0,0,1,0, 0,8'h00,0,1,0,0);
        tbl[20] = v(1,1,8'hA1,0,1,0, 1,8'hA0,0,2,0,0);
        tbl[21] = v(1,1,8'hA2,0,1,0, 1,8'hA0,0,3,0,0);
        tbl[22] = v(1,1,8'hA3,0,1,0, 1,8'hA0,0,4,0,0);
        tbl[23] = v(0,1,8'h00,1,1,0, 1,8'hA0,0,3,0,0);
        tbl[24] = v(0,1,8'h00,1,1,0, 1,8'hA1,0,2,0,0);
        tbl[25] = v(0,1,8'h00,1,1,0, 1,8'hA2,0,1,0,0);
        tbl[26] = v(0,1,8'h00,1,1,0, 1,8'hA3,0,0,0,0);

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_state();
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            run(tbl[i].pu, tbl[i].pch, tbl[i].d, tbl[i].po, tbl[i].poch, tbl[i].cl, ft, fv);
            chk($sformatf("tbl%0d_fv", i), fv, tbl[i].fv);
            if (tbl[i].fv) chk($sformatf("tbl%0d_fd", i), ft, tbl[i].fd);
            chk($sformatf("tbl%0d_c0", i), cnt_of(cnt0, 0), tbl[i].c0);
            chk($sformatf("tbl%0d_c1", i), cnt_of(cnt0, 1), tbl[i].c1);
            chk($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ov);
            chk($sformatf("tbl%0d_udf", i), udf0, tbl[i].ud);
        end

        for (int i = 0; i < 5; i++) run(1, 0, 8'h21 + 8'(i), 0, 0, 0, ft, fv);
        run(1, 0, 8'h77, 1, 0, 0, ft, fv);
        chk("full_swap_head", ft, 8'h21);
        chk("full_swap_count", cnt_of(cnt0, 0), 5);
        chk("full_swap_ovf", ovf0, 0);
        for (int i = 0; i < 5; i++) run(0, 0, 0, 1, 0, 0, ft, fv);
        chk("full_swap_last", ft, 8'h77);

        run(1, 0, 8'h01, 0, 0, 0, ft, fv);
        run(1, 1, 8'h02, 0, 0, 0, ft, fv);
        run(1, 0, 8'h03, 1, 1, 0, ft, fv);
        chk("xch_ft", ft, 8'h02);
        chk("xch_c0", cnt_of(cnt0, 0), 2);
        chk("xch_empty1", empty0[1], 1);
        chk("xch_reg_data", dout1, 8'h02);
        chk("xch_reg_vld", vld1, 1);
        run(0, 0, 0, 1, 0, 0, ft, fv);
        run(0, 0, 0, 1, 0, 0, ft, fv);

        for (int i = 0; i < 4; i++) run(1, 0, 8'h40 + 8'(i), 0, 0, 0, ft, fv);
        run(1, 1, 8'h55, 1, 0, 0, ft, fv);
        run(0, 0, 0, 1, 1, 0, ft, fv);
        run(0, 0, 0, 1, 1, 0, ft, fv);
        chk("pre_rst_c0", cnt_of(cnt0, 0), 3);
        chk("pre_rst_udf", udf0, 1);
        @(negedge clk);
        pop = 0; push = 0; clr = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_c0", cnt_of(cnt0, 0), 0);
        chk("arst_cnt1", cnt1, 0);
        chk("arst_empty", empty0, 2'b11);
        chk("arst_full", full1, 2'b00);
        chk("arst_udf", udf0, 0);
        chk("arst_reg_vld", vld1, 0);
        chk("arst_reg_data", dout1, 8'h00);
        @(negedge clk);
        rst_n = 1;

        run(0, 0, 0, 1, 0, 0, ft, fv);
        chk("udf_set", udf0, 1);
        run(0, 0, 0, 1, 1, 1, ft, fv);
        chk("clr_vs_err", udf1, 1);
        run(0, 0, 0, 0, 0, 1, ft, fv);
        chk("clr_done", udf0, 0);

        for (int i = 0; i < 400; i++)
            run($urandom_range(0, 2) != 0, $urandom_range(0, 1), 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 15) == 0,
                ft, fv);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
